inst_decoder: RTL and testbench
===============================

Name: inst_decoder

Overview:
- Core-side receiver of the 17-bit instruction word issued by the host/bench each cycle.
- Registers the word, splits it into per-unit strobes (Q/K/P memories, L0 load, MAC execute, output FIFO read) with addresses, and tracks the operating phase.
- Enforces protocol rules: illegal combinations are suppressed and reported through a sticky error.
- Sits between the `inst` input of the core and its memory, L0, MAC-array and OFIFO control pins.

Parameters:
- col, 8, number of dot-product columns = number of K rows that must be loaded before execute is legal
- addr_bw, 4, width of the qk and pmem address fields
- inst_bw, 17, instruction word width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- inst  input  17  [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr
- ofifo_valid  input  1  output FIFO holds at least one entry
- q_rd, q_wr, k_rd, k_wr, p_rd, p_wr  output  1 each  decoded memory strobes
- qk_addr  output  addr_bw  registered qkmem_add
- p_addr  output  addr_bw  registered pmem_add
- l0_load  output  1  load strobe to L0/MAC array
- mac_exec  output  1  execute strobe
- ofifo_rd  output  1  output FIFO pop
- phase  output  3  0 IDLE, 1 QWR, 2 KWR, 3 KLOAD, 4 EXEC, 5 DRAIN, 6 PRD
- k_loaded  output  1  col K rows accepted since last load start
- exec_cnt  output  4  accepted execute cycles since last load start, saturating at 15
- err  output  1  sticky protocol-error flag
- err_code  output  3  code of the first error since reset

Behaviour:
- Reset: when reset==0 at a posedge, all outputs go to 0 and phase=IDLE. Counters and the error state clear. This applies mid-operation; no strobe is emitted in the cycle after a reset edge.
- Latency: `inst` is sampled at posedge N. Strobes and addresses are valid after posedge N and held exactly one cycle, so the output registers equal that cycle's decode. Addresses are registered every cycle regardless of strobes.
- E1 (code 1): rd and wr asserted together on the same memory (Q, K or P). Both strobes of that memory are suppressed; other fields are still decoded.
- E2 (code 2): execute while k_loaded==0 after this cycle's update. mac_exec and q_rd are suppressed.
- E3 (code 3): ofifo_rd while ofifo_valid==0. ofifo_rd and p_wr are suppressed.
- E4 (code 4): load and execute in the same word. l0_load, mac_exec, k_rd and q_rd are all suppressed.
- Simultaneous errors: err_code records the lowest code. Only the first error sets err_code; err stays 1 until reset.
- K load tracking:
  - Rising edge of accepted load (load now, not in previous word) clears the kload count, k_loaded and exec_cnt.
  - Each accepted word with load & kmem_rd increments the kload count, saturating at col.
  - k_loaded=1 when count==col.
  - kmem_rd without load is passed through and does not count.
- exec_cnt: increments on each accepted execute and saturates at 15.
- phase: reflects the highest-priority accepted op of the sampled word. Priority is EXEC > KLOAD (load) > DRAIN (ofifo_rd or p_wr) > PRD (p_rd) > QWR (q_wr) > KWR (k_wr). Otherwise phase=IDLE. A fully suppressed word yields IDLE.
- Address wrap: the address fields are passed unchanged; no range checking. 4'hF followed by 4'h0 is legal.

Test Plan:
- Reset mid-op: inst=17'h00010 (qmem_wr) streaming, drop reset for 1 cycle → next cycle all strobes 0 and phase=0; on release, q_wr=1 one cycle after the next sample.
- Q write sequence: 8 words with qmem_wr and qkmem_add 0..7 → q_wr=1 and qk_addr=0..7 each one cycle late, phase=1, err=0.
- K load: load for 9 cycles, kmem_rd from cycle 1, 8 accepted rows → k_loaded rises after the 8th row, remaining 0 before it. Then 8 execute words → mac_exec=1 ×8, exec_cnt=8, phase=4.
- Execute before load (after reset) → mac_exec=0, q_rd=0, err=1, err_code=2. A later E1 leaves err_code=2.
- Drain with ofifo_valid=1 for 8 cycles, ofifo_rd+pmem_wr, pmem_add 0..7 → ofifo_rd=p_wr=1 ×8, phase=5. Repeat with ofifo_valid=0 → both suppressed, err_code=3.
- Word with load+execute and pmem_rd+pmem_wr together → l0_load=mac_exec=p_rd=p_wr=0, phase=0, err_code=1.

Source files
------------

// File: rtl/inst_decoder.sv
// Instruction-word decoder: registers the 17-bit host word, splits it into
// per-unit strobes, enforces protocol rules and tracks the operating phase.

module mem_strobe_dec (
  input  logic rd,
  input  logic wr,
  input  logic kill_rd,
  input  logic kill_wr,
  output logic rd_ok,
  output logic wr_ok,
  output logic clash
);
  always_comb begin
    clash = rd & wr;
    rd_ok = rd & ~clash & ~kill_rd;
    wr_ok = wr & ~clash & ~kill_wr;
  end
endmodule

module inst_decoder #(
  parameter int col     = 8,
  parameter int addr_bw = 4,
  parameter int inst_bw = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [inst_bw-1:0] inst,
  input  logic               ofifo_valid,
  output logic               q_rd,
  output logic               q_wr,
  output logic               k_rd,
  output logic               k_wr,
  output logic               p_rd,
  output logic               p_wr,
  output logic [addr_bw-1:0] qk_addr,
  output logic [addr_bw-1:0] p_addr,
  output logic               l0_load,
  output logic               mac_exec,
  output logic               ofifo_rd,
  output logic [2:0]         phase,
  output logic               k_loaded,
  output logic [3:0]         exec_cnt,
  output logic               err,
  output logic [2:0]         err_code
);
  localparam int NUM_MEM = 3;  // 0:P 1:K 2:Q
  localparam int CW = $clog2(col + 1);
  localparam logic [CW-1:0] COL_V = CW'(col);

  typedef enum logic [2:0] {
    PH_IDLE, PH_QWR, PH_KWR, PH_KLOAD, PH_EXEC, PH_DRAIN, PH_PRD
  } phase_e;

  typedef struct packed {
    logic               ofifo_rd;
    logic [addr_bw-1:0] qk_add;
    logic [addr_bw-1:0] p_add;
    logic               execute;
    logic               load;
    logic [NUM_MEM-1:0] rd;
    logic [NUM_MEM-1:0] wr;
  } word_t;

  word_t              w;
  logic [NUM_MEM-1:0] kill_rd, kill_wr, rd_ok, wr_ok, clash;
  logic               e1, e2, e3, e4;
  logic               ld_ok, ex_ok, ofr_ok, rise, k_inc;
  logic [CW-1:0]      cnt_q, cnt_base, cnt_nx;
  logic               k_loaded_nx;
  logic [3:0]         exec_base, exec_nx;
  logic [2:0]         code_nx;
  phase_e             phase_nx;

  always_comb begin
    w.ofifo_rd = inst[16];
    w.qk_add   = inst[12 +: addr_bw];
    w.p_add    = inst[8 +: addr_bw];
    w.execute  = inst[7];
    w.load     = inst[6];
    w.rd       = {inst[5], inst[3], inst[1]};
    w.wr       = {inst[4], inst[2], inst[0]};
  end

  genvar m;
  generate
    for (m = 0; m < NUM_MEM; m++) begin : g_mem
      mem_strobe_dec u_dec (
        .rd      (w.rd[m]),
        .wr      (w.wr[m]),
        .kill_rd (kill_rd[m]),
        .kill_wr (kill_wr[m]),
        .rd_ok   (rd_ok[m]),
        .wr_ok   (wr_ok[m]),
        .clash   (clash[m])
      );
    end
  endgenerate

  always_comb begin
    e4     = w.load & w.execute;
    e3     = w.ofifo_rd & ~ofifo_valid;
    e1     = |clash;
    ld_ok  = w.load & ~e4;
    rise   = ld_ok & ~l0_load;
    // K row counts only when both load and an unclashed kmem_rd are accepted
    k_inc  = ld_ok & w.rd[1] & ~w.wr[1];

    cnt_base = rise ? '0 : cnt_q;
    cnt_nx   = cnt_base;
    if (k_inc && cnt_base < COL_V) cnt_nx = cnt_base + CW'(1);
    k_loaded_nx = (cnt_nx == COL_V);

    e2     = w.execute & ~k_loaded_nx;
    ex_ok  = w.execute & ~e2 & ~e4;
    ofr_ok = w.ofifo_rd & ~e3;

    exec_base = rise ? 4'd0 : exec_cnt;
    exec_nx   = exec_base;
    if (ex_ok && exec_base != 4'd15) exec_nx = exec_base + 4'd1;

    kill_rd = {e2 | e4, e4, 1'b0};
    kill_wr = {1'b0, 1'b0, e3};

    code_nx = e1 ? 3'd1 : e2 ? 3'd2 : e3 ? 3'd3 : 3'd4;

    phase_nx = PH_IDLE;
    if (ex_ok)                 phase_nx = PH_EXEC;
    else if (ld_ok)            phase_nx = PH_KLOAD;
    else if (ofr_ok | wr_ok[0]) phase_nx = PH_DRAIN;
    else if (rd_ok[0])         phase_nx = PH_PRD;
    else if (wr_ok[2])         phase_nx = PH_QWR;
    else if (wr_ok[1])         phase_nx = PH_KWR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_rd     <= 1'b0;
      q_wr     <= 1'b0;
      k_rd     <= 1'b0;
      k_wr     <= 1'b0;
      p_rd     <= 1'b0;
      p_wr     <= 1'b0;
      qk_addr  <= '0;
      p_addr   <= '0;
      l0_load  <= 1'b0;
      mac_exec <= 1'b0;
      ofifo_rd <= 1'b0;
      phase    <= PH_IDLE;
      cnt_q    <= '0;
      k_loaded <= 1'b0;
      exec_cnt <= 4'd0;
      err      <= 1'b0;
      err_code <= 3'd0;
    end else begin
      q_rd     <= rd_ok[2];
      q_wr     <= wr_ok[2];
      k_rd     <= rd_ok[1];
      k_wr     <= wr_ok[1];
      p_rd     <= rd_ok[0];
      p_wr     <= wr_ok[0];
      qk_addr  <= w.qk_add;
      p_addr   <= w.p_add;
      l0_load  <= ld_ok;
      mac_exec <= ex_ok;
      ofifo_rd <= ofr_ok;
      phase    <= phase_nx;
      cnt_q    <= cnt_nx;
      k_loaded <= k_loaded_nx;
      exec_cnt <= exec_nx;
      // only the first error is latched; later ones leave the code alone
      if (!err && (e1 | e2 | e3 | e4)) begin
        err      <= 1'b1;
        err_code <= code_nx;
      end
    end
  end
endmodule

// File: tb/tb_inst_decoder.sv
// Directed bench for inst_decoder: a vector table plus hand-built K-load,
// execute and drain sequences, all with hand-computed expectations.

module tb_inst_decoder;
  logic        clk = 1'b0;
  logic        reset;
  logic [16:0] inst;
  logic        ofifo_valid;
  logic        q_rd, q_wr, k_rd, k_wr, p_rd, p_wr;
  logic [3:0]  qk_addr, p_addr;
  logic        l0_load, mac_exec, ofifo_rd;
  logic [2:0]  phase;
  logic        k_loaded;
  logic [3:0]  exec_cnt;
  logic        err;
  logic [2:0]  err_code;

  int total = 0;
  int bad   = 0;

  inst_decoder #(.col(8), .addr_bw(4), .inst_bw(17)) dut (
    .clk(clk), .reset(reset), .inst(inst), .ofifo_valid(ofifo_valid),
    .q_rd(q_rd), .q_wr(q_wr), .k_rd(k_rd), .k_wr(k_wr), .p_rd(p_rd), .p_wr(p_wr),
    .qk_addr(qk_addr), .p_addr(p_addr), .l0_load(l0_load), .mac_exec(mac_exec),
    .ofifo_rd(ofifo_rd), .phase(phase), .k_loaded(k_loaded), .exec_cnt(exec_cnt),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // stb = {ofifo_rd, mac_exec, l0_load, q_rd, q_wr, k_rd, k_wr, p_rd, p_wr}
  typedef struct {
    string       name;
    logic        rst_n;
    logic [16:0] inst;
    logic        ov;
    logic [8:0]  stb;
    logic [3:0]  qa;
    logic [3:0]  pa;
    logic [2:0]  ph;
    logic        kl;
    logic [3:0]  ec;
    logic        er;
    logic [2:0]  code;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic rst_n, logic [16:0] i, logic ov,
                              logic [8:0] stb, logic [3:0] qa, logic [3:0] pa,
                              logic [2:0] ph, logic kl, logic [3:0] ec, logic er,
                              logic [2:0] code);
    vec_t v;
    v.name = name; v.rst_n = rst_n; v.inst = i; v.ov = ov; v.stb = stb;
    v.qa = qa; v.pa = pa; v.ph = ph; v.kl = kl; v.ec = ec; v.er = er; v.code = code;
    return v;
  endfunction

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, exp);
    end
  endtask

  task automatic run(vec_t v);
    @(negedge clk);
    reset = v.rst_n; inst = v.inst; ofifo_valid = v.ov;
    @(posedge clk);
    #1;
    chk(v.name, "stb", {23'd0, ofifo_rd, mac_exec, l0_load, q_rd, q_wr, k_rd, k_wr, p_rd, p_wr},
        {23'd0, v.stb});
    chk(v.name, "qk_addr", {28'd0, qk_addr}, {28'd0, v.qa});
    chk(v.name, "p_addr", {28'd0, p_addr}, {28'd0, v.pa});
    chk(v.name, "phase", {29'd0, phase}, {29'd0, v.ph});
    chk(v.name, "k_loaded", {31'd0, k_loaded}, {31'd0, v.kl});
    chk(v.name, "exec_cnt", {28'd0, exec_cnt}, {28'd0, v.ec});
    chk(v.name, "err", {31'd0, err}, {31'd0, v.er});
    chk(v.name, "err_code", {29'd0, err_code}, {29'd0, v.code});
  endtask

  initial begin
    reset = 1'b0; inst = '0; ofifo_valid = 1'b0;

    // reset, mid-op reset, Q write stream, address wrap, phase priorities, early execute
    tbl.push_back(mk("rst0",   0, 17'h00000, 0, 9'b000000000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rst1",   0, 17'h00010, 0, 9'b000000000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("qwr_a",  1, 17'h00010, 0, 9'b000010000, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("midrst", 0, 17'h00010, 0, 9'b000000000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("qwr_b",  1, 17'h00010, 0, 9'b000010000, 0, 0, 1, 0, 0, 0, 0));
    foreach (tbl[i]) run(tbl[i]);
    tbl.delete();

    for (int i = 0; i < 8; i++)
      run(mk("qseq", 1, 17'h00010 | (17'(i) << 12), 0, 9'b000010000, 4'(i), 0, 1, 0, 0, 0, 0));

    tbl.push_back(mk("wrapF",  1, 17'h0F010, 0, 9'b000010000, 4'hF, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("wrap0",  1, 17'h00010, 0, 9'b000010000, 4'h0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("prd",    1, 17'h00502, 0, 9'b000000010, 0, 5, 6, 0, 0, 0, 0));
    tbl.push_back(mk("kwr",    1, 17'h03004, 0, 9'b000000100, 3, 0, 2, 0, 0, 0, 0));
    tbl.push_back(mk("prio",   1, 17'h00012, 0, 9'b000010010, 0, 0, 6, 0, 0, 0, 0));
    tbl.push_back(mk("rst2",   0, 17'h00000, 0, 9'b000000000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("exe_early", 1, 17'h000A0, 0, 9'b000000000, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk("e1_later",  1, 17'h00030, 0, 9'b000000000, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk("rst3",   0, 17'h00000, 0, 9'b000000000, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) run(tbl[i]);
    tbl.delete();

    // K load: first load word has no kmem_rd, then 8 counted rows
    run(mk("kload0", 1, 17'h00040, 0, 9'b001000000, 0, 0, 3, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++)
      run(mk("kload", 1, 17'h00048, 0, 9'b001001000, 0, 0, 3, (i == 8), 0, 0, 0));
    // execute until exec_cnt saturates
    for (int i = 0; i < 17; i++)
      run(mk("exec", 1, 17'h00080, 0, 9'b010000000, 0, 0, 4, 1, (i >= 14) ? 4'd15 : 4'(i + 1), 0, 0));
    run(mk("krd_only", 1, 17'h00008, 0, 9'b000001000, 0, 0, 0, 1, 15, 0, 0));
    run(mk("reload",   1, 17'h00040, 0, 9'b001000000, 0, 0, 3, 0, 0, 0, 0));

    // drain with and without FIFO data
    for (int i = 0; i < 8; i++)
      run(mk("drain", 1, 17'h10001 | (17'(i) << 8), 1, 9'b100000001, 0, 4'(i), 5, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      run(mk("drain_empty", 1, 17'h10001 | (17'(i) << 8), 0, 9'b000000000, 0, 4'(i), 0, 0, 0, 1, 3));

    tbl.push_back(mk("rst4",  0, 17'h00000, 0, 9'b000000000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("combo", 1, 17'h000C3, 0, 9'b000000000, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk("after", 1, 17'h00010, 0, 9'b000010000, 0, 0, 1, 0, 0, 1, 1));
    foreach (tbl[i]) run(tbl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
